// File: rtl/constants.sv
// Fetch-path constants: the nop substituted for faulting fetches and the fetch FSM states.
package constants;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/wires.sv
// Bundled port views of the fetch buffer and the 65-bit buffered entry (instr, pc, fault).
package wires;

    typedef struct packed {
        logic        imem_ready;
        logic        imem_rvalid;
        logic [31:0] imem_rdata;
        logic        imem_error;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        instr_ready;
    } fetch_in_type;

    typedef struct packed {
        logic        imem_valid;
        logic [31:0] imem_addr;
        logic        instr_valid;
        logic [31:0] instr;
        logic [31:0] instr_pc;
        logic        instr_fault;
    } fetch_out_type;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO with synchronous flush; head shows EMPTY_VAL when empty.
// Latency: push visible at head next cycle; backpressure: push dropped when full unless popping.
module fetch_fifo #(
    parameter int               DEPTH     = 4,
    parameter int               WIDTH     = 65,
    parameter logic [WIDTH-1:0] EMPTY_VAL = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A pop frees the head slot in the same cycle, so a full FIFO can still take a push.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? EMPTY_VAL : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer: issues sequential word fetches and queues in-order responses for the decoder.
// Latency: response to instr_valid 1 cycle (0 with FETCH_BYPASS_EN when empty and instr_ready).
// Backpressure: fetches stop once buffered + outstanding reach DEPTH; HALT after a faulting fetch.
module fetch_buffer
    import constants::*;
    import wires::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_valid,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_fault
);
    localparam int              CW          = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_W     = (CW+1)'(DEPTH);
    localparam fetch_entry_t    EMPTY_ENTRY = '{instr: NOP_INSTR, pc: 32'h0, fault: 1'b0};

    fetch_in_type  fin;
    fetch_out_type fout;

    fetch_state_e  state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] disc_q, disc_d;

    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty, fifo_push, fifo_pop;
    fetch_entry_t  fifo_head, resp_entry, head;
    logic [31:0]   redir_tgt;
    logic          resp_vld, resp_drop, resp_keep, bypass;
    logic          room, req_vld, req_fire;

    always_comb begin
        fin.imem_ready  = imem_ready;
        fin.imem_rvalid = imem_rvalid;
        fin.imem_rdata  = imem_rdata;
        fin.imem_error  = imem_error;
        fin.redirect    = redirect;
        fin.redirect_pc = redirect_pc;
        fin.instr_ready = instr_ready;
    end

    always_comb begin
        redir_tgt  = fin.redirect_pc & 32'hFFFF_FFFC;
        // Responses with nothing outstanding belong to pre-reset requests and are ignored.
        resp_vld   = fin.imem_rvalid && (out_cnt_q != '0);
        resp_drop  = resp_vld && (disc_q != '0);
        resp_keep  = resp_vld && (disc_q == '0) && !fin.redirect;
        resp_entry = '{instr: fin.imem_error ? NOP_INSTR : fin.imem_rdata,
                       pc:    resp_pc_q,
                       fault: fin.imem_error};

        room     = ({1'b0, fifo_cnt} + {1'b0, out_cnt_q}) < DEPTH_W;
        req_vld  = (state_q == ST_RUN) && !fin.redirect && room;
        req_fire = req_vld && fin.imem_ready;

`ifdef FETCH_BYPASS_EN
        bypass = resp_keep && fifo_empty && fin.instr_ready;
`else
        bypass = 1'b0;
`endif
        fifo_push = resp_keep && !bypass;
        fifo_pop  = !fin.redirect && !fifo_empty && fin.instr_ready;
        head      = bypass ? resp_entry : fifo_head;

        out_cnt_d = out_cnt_q + CW'(req_fire) - CW'(resp_vld);

        disc_d = disc_q;
        if (fin.redirect)   disc_d = out_cnt_q - CW'(resp_vld);
        else if (resp_drop) disc_d = disc_q - CW'(1);

        addr_d = addr_q;
        if (fin.redirect)  addr_d = redir_tgt;
        else if (req_fire) addr_d = addr_q + 32'd4;

        // Requests are contiguous since the last restart, so the next response pc is a counter.
        resp_pc_d = resp_pc_q;
        if (fin.redirect)   resp_pc_d = redir_tgt;
        else if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;

        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  if (resp_keep && fin.imem_error) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_INIT;
        endcase
        if (fin.redirect) state_d = ST_RUN;

        fout.imem_valid  = req_vld;
        fout.imem_addr   = addr_q;
        fout.instr_valid = !fin.redirect && (!fifo_empty || bypass);
        fout.instr       = head.instr;
        fout.instr_pc    = head.pc;
        fout.instr_fault = head.fault;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_INIT;
            addr_q    <= RESET_PC;
            resp_pc_q <= RESET_PC;
            out_cnt_q <= '0;
            disc_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            resp_pc_q <= resp_pc_d;
            out_cnt_q <= out_cnt_d;
            disc_q    <= disc_d;
        end
    end

    fetch_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (65),
        .EMPTY_VAL (EMPTY_ENTRY)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (fin.redirect),
        .push  (fifo_push),
        .wdata (resp_entry),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign imem_valid  = fout.imem_valid;
    assign imem_addr   = fout.imem_addr;
    assign instr_valid = fout.instr_valid;
    assign instr       = fout.instr;
    assign instr_pc    = fout.instr_pc;
    assign instr_fault = fout.instr_fault;

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: random memory/decoder/redirect traffic against a program-order stream model.
module tb_fetch_buffer;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_valid, imem_ready, imem_rvalid, imem_error;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready, instr_fault;
    logic [31:0] instr, instr_pc;

    always #5 clock = ~clock;

    fetch_buffer #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_valid  (imem_valid),
        .imem_ready  (imem_ready),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .imem_error  (imem_error),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Memory side: in-order responses, each tagged with the redirect epoch it was issued in.
    typedef struct {
        logic [31:0] addr;
        logic        err;
        int          epoch;
        int          due;
    } req_t;
    req_t memq[$];

    int          p_ready = 100, p_iready = 0, lat_min = 1, lat_max = 1;
    bit          err_rand_en = 0, force_err_en = 0;
    logic [31:0] force_err_addr = 32'h0;
    bit          redir_req = 0;
    logic [31:0] redir_tgt = 32'h0;

    // Program-order model: after each restart the decoder sees pc, pc+4, ... with memory contents.
    int          cyc = 0, epoch = 0, ep_acc = 0, ep_pop = 0;
    logic [31:0] exp_req_addr = RST_PC, exp_pc = RST_PC;
    bit          halted = 0;
    bit          exp_fault [bit [31:0]];
    int          fires = 0, stale = 0;
    bit          prev_wait = 0, prev_fault = 0;
    logic [31:0] prev_addr = 32'h0;
    bit          last_fire, last_pop, last_rsp, last_vld, last_ivld;
    logic [31:0] last_addr, last_ipc, last_instr;
    logic        last_ifault;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        logic [31:0] h;
        h = (a >> 2) * 32'h9E37_79B1;
        return (err_rand_en && h[31:27] == 5'd0) || (force_err_en && a == force_err_addr);
    endfunction

    task automatic step();
        bit   rsp;
        bit   fault_now;
        req_t r;
        fault_now   = 0;
        imem_ready  = ($urandom_range(99) < p_ready);
        instr_ready = ($urandom_range(99) < p_iready);
        redirect    = redir_req;
        redirect_pc = redir_tgt;
        redir_req   = 0;
        rsp = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid = rsp;
        if (rsp) begin
            r = memq.pop_front();
            imem_rdata = mem_data(r.addr);
            imem_error = r.err;
        end else begin
            imem_rdata = $urandom;
            imem_error = 1'($urandom_range(1));
        end
        #1;
        if (redirect) begin
            check("redirect_imem_valid", imem_valid, 0);
            check("redirect_instr_valid", instr_valid, 0);
            epoch++;
            exp_req_addr = redirect_pc & 32'hFFFF_FFFC;
            exp_pc = exp_req_addr;
            halted = 0;
            ep_acc = 0;
            ep_pop = 0;
            exp_fault.delete();
        end else if (prev_wait && !prev_fault) begin
            check("hold_imem_valid", imem_valid, 1);
            check("hold_imem_addr", imem_addr, prev_addr);
        end
        if (rsp) begin
            if (r.epoch != epoch) stale++;
            else begin
                exp_fault[r.addr] = r.err;
                fault_now = r.err;
            end
        end
        last_fire = imem_valid && imem_ready;
        if (last_fire) begin
            check("req_addr", imem_addr, exp_req_addr);
            check("req_while_halted", halted, 0);
            memq.push_back('{addr: imem_addr, err: mem_err(imem_addr), epoch: epoch,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
            exp_req_addr += 32'd4;
            ep_acc++;
            fires++;
        end
        last_pop = instr_valid && instr_ready;
        if (last_pop) begin
            check("pop_pc", instr_pc, exp_pc);
            check("pop_was_fetched", exp_fault.exists(exp_pc), 1);
            if (exp_fault.exists(exp_pc)) begin
                check("pop_instr", instr, exp_fault[exp_pc] ? NOP : mem_data(exp_pc));
                check("pop_fault", instr_fault, exp_fault[exp_pc]);
            end
            exp_pc += 32'd4;
            ep_pop++;
        end
        check("occupancy_bound", (ep_acc - ep_pop) <= DEPTH, 1);
        last_rsp    = rsp;
        last_vld    = imem_valid;
        last_addr   = imem_addr;
        last_ivld   = instr_valid;
        last_ipc    = instr_pc;
        last_instr  = instr;
        last_ifault = instr_fault;
        prev_wait   = imem_valid && !imem_ready;
        prev_addr   = imem_addr;
        prev_fault  = fault_now;
        if (fault_now) halted = 1;
        @(posedge clock);
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0; imem_error = 0;
        redirect = 0; redirect_pc = 0; instr_ready = 0;
        redir_req = 0;
        memq.delete();
        exp_fault.delete();
        epoch++;
        exp_req_addr = RST_PC; exp_pc = RST_PC;
        halted = 0; ep_acc = 0; ep_pop = 0; fires = 0;
        prev_wait = 0; prev_fault = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_imem_valid", imem_valid, 0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_instr_fault", instr_fault, 0);
        reset = 1;
    endtask

    task automatic drain();
        p_ready  = 0;
        p_iready = 100;
        for (int i = 0; i < 200 && (memq.size() > 0 || last_ivld); i++) step();
        check("drain_done", (memq.size() == 0) && !last_ivld, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          got;
        int          f0, s0;
        logic [31:0] tgt;

        do_reset();
        p_ready = 100; p_iready = 0; lat_min = 3; lat_max = 3;
        step();
        check("init_no_request", last_vld, 0);
        step();
        check("first_req_fire", last_fire, 1);
        check("first_req_addr", last_addr, 32'h8000_0000);
        step();
        check("second_req_addr", last_addr, 32'h8000_0004);
        repeat (10) step();
        check("full_request_count", fires, 4);
        check("full_no_request", last_vld, 0);
        p_iready = 100;
        step();
        check("first_pop", last_pop, 1);
        check("no_request_before_pop", fires, 4);
        repeat (30) step();

        drain();
        lat_min = 5; lat_max = 5; p_ready = 100; p_iready = 100;
        step();
        step();
        check("two_outstanding", memq.size(), 2);
        s0 = stale;
        redir_req = 1; redir_tgt = 32'h0000_0103;
        step();
        check("redirect_cycle_no_req", last_vld, 0);
        step();
        check("redirect_first_fire", last_fire, 1);
        check("redirect_first_addr", last_addr, 32'h0000_0100);
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (last_pop) begin
                got = 1;
                check("redirect_first_pc", last_ipc, 32'h0000_0100);
            end
        end
        check("redirect_pop_seen", got, 1);
        check("stale_dropped", stale - s0, 2);

        drain();
        force_err_en = 1; force_err_addr = 32'h10;
        lat_min = 2; lat_max = 2; p_ready = 100; p_iready = 0;
        redir_req = 1; redir_tgt = 32'h10;
        step();
        for (int i = 0; i < 20 && !halted; i++) step();
        check("fault_response_seen", halted, 1);
        f0 = fires;
        p_iready = 100;
        got = 0;
        repeat (20) begin
            step();
            if (last_pop && last_ipc == 32'h10) begin
                got = 1;
                check("fault_instr_nop", last_instr, NOP);
                check("fault_flag", last_ifault, 1);
            end
        end
        check("fault_entry_popped", got, 1);
        check("halt_no_new_requests", fires, f0);
        check("halt_imem_valid_low", last_vld, 0);
        force_err_en = 0;

        p_ready = 0;
        redir_req = 1; redir_tgt = 32'h200;
        step();
        drain();
        lat_min = 3; lat_max = 3; p_ready = 100; p_iready = 100;
        step();
        check("latency_fire", last_fire, 1);
        p_ready = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            if (last_rsp) begin
                got = 1;
                check("latency_same_cycle", last_ivld, BYP);
            end
        end
        check("latency_response_seen", got, 1);
        step();
        check("latency_next_cycle", last_ivld, !BYP);

        p_ready = 100; p_iready = 50; lat_min = 2; lat_max = 4;
        repeat (6) step();
        do_reset();

        err_rand_en = 1;
        for (int blk = 0; blk < 15; blk++) begin
            p_ready  = $urandom_range(100, 20);
            p_iready = $urandom_range(100, 10);
            lat_min  = 1;
            lat_max  = $urandom_range(6, 1);
            repeat (200) begin
                if (!redir_req && $urandom_range(99) < (halted ? 10 : 2)) begin
                    if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                    else tgt = $urandom & 32'h0000_3FFF;
                    redir_req = 1;
                    redir_tgt = tgt;
                end
                step();
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
